tick_gen_multi: RTL

- Parametrised, multi-channel successor to the fixed 1 Hz divider. It generates NUM_CH independent timebases from clk_50Mhz.
- Each channel provides a one-cycle tick strobe (clock-enable) and a near-50%-duty square wave.
- Divisors are runtime-programmable through a valid/ready config port. New values apply glitch-free at the next period boundary.
- Feeds the clock core (1 Hz seconds), the display blink (2 Hz) and the digit scan (1 kHz) from one block, all on the single clock domain.

---
 rtl/tick_gen_multi_if.sv | 12 +
 rtl/tick_gen_multi.sv | 94 +++++++++
 2 files changed

// File: rtl/tick_gen_multi_if.sv
// Config port for tick_gen_multi: valid/ready write of one channel divisor.
interface tick_gen_multi_if #(
   parameter int CNT_W = 26
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [2:0]       cfg_ch;
   logic [CNT_W-1:0] cfg_div;

   modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel timebase: per channel a one-cycle tick strobe and a square
// wave, divisor reloadable at runtime and applied only at a period boundary.
module tick_gen_multi #(
   parameter int CLK_HZ = 50_000_000,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 26,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(CLK_HZ/1000), CNT_W'(CLK_HZ/1000),
                                                  CNT_W'(CLK_HZ/2),    CNT_W'(CLK_HZ)}
) (
   input  logic              clk_50Mhz,
   input  logic              rst_n,
   input  logic              en,
   input  logic              sync_clr,
   tick_gen_multi_if.slave   cfg,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq
);

   logic [NUM_CH-1:0] pending;
   logic [7:0]        pending_ext;

   // Widen pending to the full cfg_ch range; unused channels read as free so
   // writes to them complete a handshake and are dropped.
   always_comb begin
      pending_ext = '0;
      pending_ext[NUM_CH-1:0] = pending;
   end

   assign cfg.cfg_ready = ~pending_ext[cfg.cfg_ch];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [CNT_W-1:0] INIT = DIV_INIT[i*CNT_W +: CNT_W];

      logic [CNT_W-1:0] cnt, div, shadow, last, rise;
      logic             run, wrap, acc, apply, pend, tick_r, sq_r;

      assign last  = div - CNT_W'(1);
      // sq goes high for the last floor(div/2) counts of the period, so odd
      // divisors get the shorter high phase and the fall lands on the tick.
      assign rise  = div - (div >> 1) - CNT_W'(1);
      assign run   = (div > CNT_W'(1));
      assign wrap  = en && run && (cnt == last);
      assign acc   = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == 3'(i));
      assign apply = pend && (sync_clr || wrap || !run);

      assign pending[i] = pend;
      assign tick[i]    = tick_r;
      assign sq[i]      = sq_r;

      // Period counter, tick strobe and square wave; sync_clr outranks en and wrap.
      always_ff @(posedge clk_50Mhz or negedge rst_n) begin
         if (!rst_n) begin
            cnt    <= '0;
            tick_r <= 1'b0;
            sq_r   <= 1'b0;
         end else if (sync_clr) begin
            cnt    <= '0;
            tick_r <= 1'b0;
            sq_r   <= 1'b0;
         end else if (!run) begin
            cnt    <= '0;
            sq_r   <= 1'b0;
            tick_r <= en && (div == CNT_W'(1));
         end else if (!en) begin
            tick_r <= 1'b0;
         end else if (wrap) begin
            cnt    <= '0;
            tick_r <= 1'b1;
            sq_r   <= 1'b0;
         end else begin
            cnt    <= cnt + CNT_W'(1);
            tick_r <= 1'b0;
            if (cnt == rise) sq_r <= 1'b1;
         end
      end

      // Shadow divisor capture and boundary apply; accept and apply never
      // coincide because a pending channel is not ready.
      always_ff @(posedge clk_50Mhz or negedge rst_n) begin
         if (!rst_n) begin
            div    <= INIT;
            shadow <= '0;
            pend   <= 1'b0;
         end else if (acc) begin
            shadow <= cfg.cfg_div;
            pend   <= 1'b1;
         end else if (apply) begin
            div    <= shadow;
            pend   <= 1'b0;
         end
      end
   end

endmodule
